instr_fetch_unit: RTL

Sequencer for the combinational `instruction_memory`. It owns the program counter and drives the memory read address each cycle. It captures the returned word together with its PC in a 2-entry fetch buffer and presents the buffered instructions to decode over a valid/ready handshake. It sits between `instruction_memory` and the decode stage, and accepts PC redirects from branch/jump resolution.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/fetch_buffer.sv | 38 +++
 rtl/instr_fetch_unit.sv | 51 +++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-path widths, reset/step constants and the buffered entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry synchronous FIFO of {pc, instr}; flush empties it and overrides push/pop
module fetch_buffer
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic [1:0]   count,
  output logic         head,
  output fetch_entry_t entries [2]
);
  fetch_entry_t r_entry [2];
  logic [1:0]   r_count;
  logic         r_head;
  logic         w_tail;
  // with count 2 the tail is the head slot, which a simultaneous pop frees
  assign w_tail = r_head ^ r_count[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry[0] <= '0;
      r_entry[1] <= '0;
      r_count    <= '0;
      r_head     <= 1'b0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      if (push) r_entry[w_tail] <= push_entry;
      if (pop) r_head <= ~r_head;
      r_count <= r_count + 2'(push) - 2'(pop);
    end
  end
  assign count   = r_count;
  assign head    = r_head;
  assign entries = r_entry;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencer for a combinational instruction memory,
// buffering fetched words for decode over a valid/ready handshake
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);
  import riscv_pkg::*;
  logic [31:0]  r_pc;
  logic [1:0]   w_count;
  logic         w_head;
  logic         w_pop;
  logic         w_push;
  fetch_entry_t w_entries [2];
  fetch_entry_t w_head_entry;
  assign w_pop  = (w_count != 2'd0) & out_ready;
  assign w_push = fetch_en & ~redirect_valid & ((w_count != 2'(DEPTH)) | w_pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= align_pc(redirect_pc);
    else if (w_push) r_pc <= r_pc + PC_STEP;
  end
  fetch_buffer u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_push),
    .pop        (w_pop),
    .flush      (redirect_valid),
    .push_entry ('{pc: r_pc, instr: imem_rdata}),
    .count      (w_count),
    .head       (w_head),
    .entries    (w_entries)
  );
  // outputs come straight from buffer registers, so no input reaches them combinationally
  assign w_head_entry = w_entries[w_head];
  assign imem_addr    = r_pc;
  assign out_valid    = w_count != 2'd0;
  assign out_pc       = w_head_entry.pc;
  assign out_instr    = w_head_entry.instr;
endmodule
